// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key generator and its GCD helper.
package rsa_pkg;

  localparam int KEY_W           = 16;
  localparam int PRIME_W         = 8;
  localparam int E_START_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    GCD_INIT = 3'd2,
    GCD      = 3'd3,
    INV_INIT = 3'd4,
    INV      = 3'd5,
    DONE     = 3'd6,
    ERR      = 3'd7
  } kg_state_e;

endpackage : rsa_pkg

// File: rtl/rsa_gcd.sv
// Subtractive GCD engine: load a/b, then one subtraction per cycle until a==b.
// done is high while the loaded pair has converged; result is the common value.
module rsa_gcd
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [KEY_W-1:0] a_in,
  input  logic [KEY_W-1:0] b_in,
  output logic             done,
  output logic [KEY_W-1:0] result
);

  logic [KEY_W-1:0] a_q, a_d;
  logic [KEY_W-1:0] b_q, b_d;
  logic             valid_q, valid_d;

  // Next operand pair: load a fresh pair, or subtract the smaller from the larger.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (load) begin
      a_d     = a_in;
      b_d     = b_in;
      valid_d = 1'b1;
    end else if (a_q > b_q) begin
      a_d = a_q - b_q;
    end else if (b_q > a_q) begin
      b_d = b_q - a_q;
    end
  end

  // Operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign done   = valid_q && (a_q == b_q);
  assign result = a_q;

endmodule : rsa_gcd

// File: rtl/rsa_keygen.sv
// Toy RSA key generator: from primes p and q, find the smallest odd e >= E_START
// coprime to phi, then the inverse d by repeated addition of e modulo phi.
module rsa_keygen
  import rsa_pkg::*;
#(
  parameter int unsigned E_START = E_START_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PRIME_W-1:0] p,
  input  logic [PRIME_W-1:0] q,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [KEY_W-1:0]   n,
  output logic [KEY_W-1:0]   e,
  output logic [KEY_W-1:0]   d
);

  kg_state_e state_q, state_d;

  logic [PRIME_W-1:0] p_q, p_d, q_q, q_d;
  logic [KEY_W-1:0]   n_q, n_d, e_q, e_d, d_q, d_d;
  logic [KEY_W-1:0]   phi_q, phi_d, cand_q, cand_d;
  logic [KEY_W-1:0]   acc_q, acc_d, k_q, k_d;
  logic               err_q, err_d;
  logic [KEY_W:0]     inv_sum;

  logic               gcd_load;
  logic               gcd_done;
  logic [KEY_W-1:0]   gcd_result;

  rsa_gcd u_gcd (
    .clk    (clk),
    .rst    (rst),
    .load   (gcd_load),
    .a_in   (cand_q),
    .b_in   (phi_q),
    .done   (gcd_done),
    .result (gcd_result)
  );

  // Next-state and datapath updates for the key-generation sequence.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    q_d      = q_q;
    n_d      = n_q;
    e_d      = e_q;
    d_d      = d_q;
    phi_d    = phi_q;
    cand_d   = cand_q;
    acc_d    = acc_q;
    k_d      = k_q;
    err_d    = err_q;
    gcd_load = 1'b0;
    inv_sum  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          p_d   = p;
          q_d   = q;
          err_d = 1'b0;
          n_d   = '0;
          e_d   = '0;
          d_d   = '0;
          // Primality is the caller's job; only trivially bad inputs are rejected.
          if (p < 2 || q < 2 || p == q) state_d = ERR;
          else                          state_d = SETUP;
        end
      end

      SETUP: begin
        n_d    = {8'd0, p_q} * {8'd0, q_q};
        phi_d  = ({8'd0, p_q} - 16'd1) * ({8'd0, q_q} - 16'd1);
        cand_d = KEY_W'(E_START);
        if (cand_d >= phi_d) state_d = ERR;
        else                 state_d = GCD_INIT;
      end

      GCD_INIT: begin
        gcd_load = 1'b1;
        state_d  = GCD;
      end

      GCD: begin
        if (gcd_done) begin
          if (gcd_result == 16'd1) begin
            e_d     = cand_q;
            state_d = INV_INIT;
          end else begin
            // cand < phi <= 65025, so cand+2 still fits in 16 bits.
            cand_d = cand_q + 16'd2;
            if (cand_d >= phi_q) state_d = ERR;
            else                 state_d = GCD_INIT;
          end
        end
      end

      INV_INIT: begin
        acc_d   = e_q;
        k_d     = 16'd1;
        state_d = INV;
      end

      INV: begin
        if (acc_q == 16'd1) begin
          d_d     = k_q;
          state_d = DONE;
        end else begin
          // acc and e are both below phi, so one conditional subtract reduces the sum.
          inv_sum = {1'b0, acc_q} + {1'b0, e_q};
          if (inv_sum >= {1'b0, phi_q}) inv_sum = inv_sum - {1'b0, phi_q};
          acc_d = inv_sum[KEY_W-1:0];
          k_d   = k_q + 16'd1;
          if (k_d == phi_q) state_d = ERR;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      ERR: begin
        err_d   = 1'b1;
        n_d     = '0;
        e_d     = '0;
        d_d     = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; synchronous reset overrides any start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      q_q    <= '0;
      n_q    <= '0;
      e_q    <= '0;
      d_q    <= '0;
      phi_q  <= '0;
      cand_q <= '0;
      acc_q  <= '0;
      k_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      p_q    <= p_d;
      q_q    <= q_d;
      n_q    <= n_d;
      e_q    <= e_d;
      d_q    <= d_d;
      phi_q  <= phi_d;
      cand_q <= cand_d;
      acc_q  <= acc_d;
      k_q    <= k_d;
      err_q  <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;
  assign n    = n_q;
  assign e    = e_q;
  assign d    = d_q;

endmodule : rsa_keygen

// File: tb/tb_rsa_keygen.sv
// Directed bench for rsa_keygen with hand-computed keys.
module tb_rsa_keygen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  p = '0;
  logic [7:0]  q = '0;
  logic        busy, done, err;
  logic [15:0] n, e, d;

  int errors = 0;
  int checks = 0;

  rsa_keygen dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .n     (n),
    .e     (e),
    .d     (d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned modexp(input int unsigned b, input int unsigned x,
                                         input int unsigned m);
    int unsigned r = 1;
    int unsigned bb = b % m;
    int unsigned xx = x;
    while (xx != 0) begin
      if (xx[0]) r = (r * bb) % m;
      bb = (bb * bb) % m;
      xx = xx >> 1;
    end
    return r;
  endfunction

  // Wait at falling edges until the block returns to IDLE, counting done pulses.
  task automatic wait_idle(output int dones, output logic timeout);
    dones   = 0;
    timeout = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  // One start pulse, then run to completion and compare the outcome.
  task automatic run_key(input string tag, input logic [7:0] pp, input logic [7:0] qq,
                         input logic [15:0] en, input logic [15:0] ee, input logic [15:0] ed,
                         input logic exp_err);
    int   dones;
    logic timeout;
    @(negedge clk);
    p     = pp;
    q     = qq;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_accept"}, busy, 1);
    wait_idle(dones, timeout);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_done_count"}, dones, exp_err ? 0 : 1);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_n"}, n, en);
    check({tag, "_e"}, e, ee);
    check({tag, "_d"}, d, ed);
  endtask

  initial begin
    int   dones;
    logic timeout;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_n", n, 0);
    check("rst_e", e, 0);
    check("rst_d", d, 0);
    rst = 1'b0;

    // Main function on several prime pairs.
    run_key("k11_13", 8'd11, 8'd13, 16'd143, 16'd7, 16'd103, 1'b0);

    // Encrypt/decrypt 65 with the key just produced.
    check("roundtrip_65", modexp(modexp(65, e, n), d, n), 65);

    // Outputs hold in IDLE.
    repeat (3) @(negedge clk);
    check("hold_d", d, 103);

    run_key("k5_11", 8'd5, 8'd11, 16'd55, 16'd3, 16'd27, 1'b0);
    run_key("k17_19", 8'd17, 8'd19, 16'd323, 16'd5, 16'd173, 1'b0);

    // Rejected inputs.
    run_key("p1", 8'd1, 8'd13, 16'd0, 16'd0, 16'd0, 1'b1);
    run_key("p_eq_q", 8'd7, 8'd7, 16'd0, 16'd0, 16'd0, 1'b1);
    // Tiny phi: E_START=3 is not below phi=2.
    run_key("phi_small", 8'd2, 8'd3, 16'd0, 16'd0, 16'd0, 1'b1);
    // Next good start clears err.
    run_key("after_err", 8'd11, 8'd13, 16'd143, 16'd7, 16'd103, 1'b0);

    // Reset while in GCD: SETUP, GCD_INIT, then GCD at the third falling edge.
    @(negedge clk);
    p     = 8'd11;
    q     = 8'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    check("mid_n_before_rst", n, 143);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_n", n, 0);
    check("mid_rst_e", e, 0);
    check("mid_rst_d", d, 0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    check("mid_rst_still_idle", busy, 0);
    run_key("after_rst", 8'd11, 8'd13, 16'd143, 16'd7, 16'd103, 1'b0);

    // Reset has priority over start in the same cycle.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_vs_start_busy", busy, 0);
    check("rst_vs_start_n", n, 0);

    // start held high: one run, then re-accepted on the first IDLE cycle after done.
    @(negedge clk);
    p     = 8'd11;
    q     = 8'd13;
    start = 1'b1;
    wait_idle(dones, timeout);
    check("held_timeout", timeout, 0);
    check("held_done_count", dones, 1);
    check("held_d", d, 103);
    @(negedge clk);
    check("held_reaccept_busy", busy, 1);
    start = 1'b0;
    wait_idle(dones, timeout);
    check("held2_timeout", timeout, 0);
    check("held2_done_count", dones, 1);
    check("held2_e", e, 7);
    check("held2_d", d, 103);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rsa_keygen
